mmio_button_ctrl: RTL



---
 rtl/mmio_pkg.sv | 30 +++
 rtl/btn_debounce.sv | 44 ++++
 rtl/mmio_button_ctrl.sv | 95 +++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared constants and types for the CPU-bus button peripheral.
package mmio_pkg;

    localparam int unsigned DATA_W          = 8;
    localparam int unsigned ADDR_W          = 8;
    localparam int unsigned MAX_BTN         = 4;
    localparam int unsigned STATUS_PEND_LSB = 4;
    localparam int unsigned PRESS_W         = 3;

    localparam logic [ADDR_W-1:0] ADDR_LED    = 8'd128;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 8'd129;
    localparam logic [ADDR_W-1:0] ADDR_COUNT  = 8'd130;

    // STATUS register layout: pending in the upper nibble, debounced levels in the lower
    typedef struct packed {
        logic [MAX_BTN-1:0] pending;
        logic [MAX_BTN-1:0] level;
    } status_t;

    // Number of buttons that registered a press on this edge
    function automatic logic [PRESS_W-1:0] popcount(input logic [MAX_BTN-1:0] v);
        logic [PRESS_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < MAX_BTN; i++) begin
            n = n + PRESS_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus hold-time debouncer for one push-button.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable,
    output logic rise_c
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_q;
    logic [CNT_W-1:0] cnt;
    logic             expire_c;

    // Level has disagreed with stable for the full hold window on this edge
    assign expire_c = (sync_q != stable) && (cnt == CNT_LAST);
    assign rise_c   = expire_c && sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            stable    <= 1'b0;
            cnt       <= '0;
        end else begin
            sync_meta <= raw;
            sync_q    <= sync_meta;
            if (sync_q == stable) begin
                cnt <= '0;
            end else if (expire_c) begin
                stable <= sync_q;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mmio_button_ctrl.sv
// Memory-mapped button peripheral: debounced levels, sticky press flags,
// press counter and interrupt level, with a registered read-data port.
module mmio_button_ctrl #(
    parameter int unsigned NUM_BTN         = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic [7:0]  ADDR_STATUS     = mmio_pkg::ADDR_STATUS,
    parameter logic [7:0]  ADDR_COUNT      = mmio_pkg::ADDR_COUNT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_BTN-1:0]          btn_raw,
    input  logic                        write,
    input  logic                        read,
    input  logic [mmio_pkg::ADDR_W-1:0] address,
    input  logic [mmio_pkg::DATA_W-1:0] wdata,
    output logic [mmio_pkg::DATA_W-1:0] rdata,
    output logic                        rdata_valid,
    output logic                        irq
);

    import mmio_pkg::*;

    logic [NUM_BTN-1:0] stable;
    logic [NUM_BTN-1:0] rise_c;
    logic [NUM_BTN-1:0] pending;
    logic [DATA_W-1:0]  count;

    logic               rd_status_c;
    logic               rd_count_c;
    logic               wr_status_c;
    logic               wr_count_c;
    logic [NUM_BTN-1:0] clr_c;
    logic [PRESS_W-1:0] presses_c;
    status_t            status_c;
    logic [DATA_W-1:0]  rdata_nxt_c;

    for (genvar g = 0; g < NUM_BTN; g++) begin : gen_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .rst_n (rst),
            .raw   (btn_raw[g]),
            .stable(stable[g]),
            .rise_c(rise_c[g])
        );
    end

    assign rd_status_c = read  && (address == ADDR_STATUS);
    assign rd_count_c  = read  && (address == ADDR_COUNT);
    assign wr_status_c = write && (address == ADDR_STATUS);
    assign wr_count_c  = write && (address == ADDR_COUNT);
    assign presses_c   = popcount(MAX_BTN'(rise_c));

    always_comb begin
        clr_c = '0;
        if (wr_status_c) begin
            clr_c = wdata[STATUS_PEND_LSB +: NUM_BTN];
        end
    end

    always_comb begin
        status_c = '0;
        status_c.level[NUM_BTN-1:0]   = stable;
        status_c.pending[NUM_BTN-1:0] = pending;
    end

    // Read mux samples pre-write register values
    always_comb begin
        rdata_nxt_c = '0;
        if (rd_status_c) begin
            rdata_nxt_c = status_c;
        end else if (rd_count_c) begin
            rdata_nxt_c = count;
        end
    end

    // New presses take priority over a same-edge clear; a COUNT write beats a press
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending     <= '0;
            count       <= '0;
            irq         <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else begin
            pending     <= (pending & ~clr_c) | rise_c;
            count       <= wr_count_c ? wdata : count + DATA_W'(presses_c);
            irq         <= |pending;
            rdata       <= rdata_nxt_c;
            rdata_valid <= rd_status_c || rd_count_c;
        end
    end

endmodule
